// File: rtl/iob_wishbone2iob_pipe_if.sv
// iob_wishbone2iob_pipe_if: signal bundle between a pipelined Wishbone master,
// the bridge, and the IOb slave behind it.
// slave modport  = the bridge's view (Wishbone slave side + IOb master side).
// master modport = the environment's view (Wishbone master + IOb slave).
interface iob_wishbone2iob_pipe_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Wishbone request side
  logic [ADDR_W-1:0]   wb_addr_i;
  logic [DATA_W/8-1:0] wb_select_i;
  logic                wb_we_i;
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic [DATA_W-1:0]   wb_data_i;
  // Wishbone response side
  logic                wb_stall_o;
  logic                wb_ack_o;
  logic                wb_error_o;
  logic [DATA_W-1:0]   wb_data_o;
  // IOb side
  logic                valid_o;
  logic [ADDR_W-1:0]   address_o;
  logic [DATA_W-1:0]   wdata_o;
  logic [DATA_W/8-1:0] wstrb_o;
  logic [DATA_W-1:0]   rdata_i;
  logic                ready_i;

  modport slave (
    input  wb_addr_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i,
    input  rdata_i, ready_i,
    output wb_stall_o, wb_ack_o, wb_error_o, wb_data_o,
    output valid_o, address_o, wdata_o, wstrb_o
  );

  modport master (
    output wb_addr_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i,
    output rdata_i, ready_i,
    input  wb_stall_o, wb_ack_o, wb_error_o, wb_data_o,
    input  valid_o, address_o, wdata_o, wstrb_o
  );
endinterface

// File: rtl/iob_wishbone2iob_pipe.sv
// iob_wishbone2iob_pipe: pipelined Wishbone slave to IOb master bridge.
// Accepted requests queue in a DEPTH-entry FIFO; the head drives the IOb bus and
// each IOb completion returns a registered ack one clock later, in request order.
// Optional macro IOB_WB2IOB_TIMEOUT_EN: a head stuck without ready_i for
// 2^TIMEOUT_W-1 cycles is dropped and answered with wb_error_o instead of wb_ack_o.
module iob_wishbone2iob_pipe #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT_W = 8
) (
  input logic clk_i,
  input logic arst_i,
  iob_wishbone2iob_pipe_if.slave bus
);
  localparam int SEL_W = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Elaboration-time parameter sanity checks
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if (TIMEOUT_W < 2) begin : g_bad_timeout_w
    $error("TIMEOUT_W must be >= 2");
  end

  // Request FIFO storage (occupancy is tracked separately, so no reset needed)
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [SEL_W-1:0]  fifo_sel  [DEPTH];
  logic              fifo_we   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  fifo_cnt_reg;
  logic [CNT_W-1:0]  outstanding_reg;
  logic              ack_reg, err_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic stall, accept, head_valid, valid, complete, pop, retire, to_fire, head_we;

  // Outstanding counts until the master has seen the response, which keeps the
  // FIFO level at or below DEPTH even with a same-cycle push and pop.
  assign stall      = (outstanding_reg == CNT_FULL);
  assign accept     = bus.wb_cyc_i & bus.wb_stb_i & ~stall;
  assign head_valid = (fifo_cnt_reg != '0);
  assign head_we    = fifo_we[rd_ptr_reg];
  assign complete   = valid & bus.ready_i;
  assign pop        = complete | to_fire;
  assign retire     = (ack_reg | err_reg) & (outstanding_reg != '0);

`ifdef IOB_WB2IOB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] to_cnt_reg;
  logic                 drop_reg;

  // Fire on the cycle the stall count reaches its terminal value.
  assign to_fire = valid & ~bus.ready_i & (to_cnt_reg == TO_LAST);
  assign valid   = head_valid & ~drop_reg;

  // Stuck-ready timer; valid_o is masked for one cycle after a timeout pop
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      to_cnt_reg <= '0;
      drop_reg   <= 1'b0;
    end else begin
      drop_reg <= to_fire;
      if (!bus.wb_cyc_i || pop) begin
        to_cnt_reg <= '0;
      end else if (valid && !bus.ready_i) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
    end
  end
`else
  assign to_fire = 1'b0;
  assign valid   = head_valid;
`endif

  // Write accepted requests at the tail slot
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_addr[wr_ptr_reg] <= bus.wb_addr_i;
      fifo_data[wr_ptr_reg] <= bus.wb_data_i;
      fifo_sel[wr_ptr_reg]  <= bus.wb_select_i;
      fifo_we[wr_ptr_reg]   <= bus.wb_we_i;
    end
  end

  // FIFO pointers and level; dropping wb_cyc_i flushes everything queued
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else if (!bus.wb_cyc_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // Outstanding request counter driving wb_stall_o
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      outstanding_reg <= '0;
    end else if (!bus.wb_cyc_i) begin
      outstanding_reg <= '0;
    end else begin
      case ({accept, retire})
        2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
        2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  // Registered Wishbone response; completions seen while the cycle is dropped are discarded
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ack_reg   <= complete & bus.wb_cyc_i;
      err_reg   <= to_fire & bus.wb_cyc_i;
      rdata_reg <= (complete && bus.wb_cyc_i && !head_we) ? bus.rdata_i : '0;
    end
  end

  assign bus.wb_stall_o = stall;
  assign bus.wb_ack_o   = ack_reg;
  assign bus.wb_error_o = err_reg;
  assign bus.wb_data_o  = rdata_reg;
  assign bus.valid_o    = valid;
  assign bus.address_o  = fifo_addr[rd_ptr_reg];
  assign bus.wdata_o    = fifo_data[rd_ptr_reg];
  assign bus.wstrb_o    = head_we ? fifo_sel[rd_ptr_reg] : '0;
endmodule

// File: tb/tb_iob_wishbone2iob_pipe.sv
// tb_iob_wishbone2iob_pipe: scoreboard bench for the Wishbone-to-IOb bridge.
// Accepted requests push an expected IOb handoff and an expected Wishbone
// response; the negedge monitor pops and compares them as the DUT produces them.
// Build with IOB_WB2IOB_TIMEOUT_EN to exercise the timeout path.
module tb_iob_wishbone2iob_pipe;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TO_W  = 8;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  iob_wishbone2iob_pipe_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  iob_wishbone2iob_pipe #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT_W(TO_W)
  ) dut (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (bus)
  );

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
  } resp_exp_t;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
  } iob_exp_t;

  resp_exp_t resp_q[$];
  iob_exp_t  iob_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int n_txn = 0;

  // IOb slave memory model: fixed word at 0x10, hashed data elsewhere
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  always_comb bus.rdata_i = rd_model(bus.address_o);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d);
    bus.wb_stb_i    = 1'b1;
    bus.wb_we_i     = we;
    bus.wb_addr_i   = a;
    bus.wb_select_i = s;
    bus.wb_data_i   = d;
    step();
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while ((resp_q.size() != 0 || iob_q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk(tag, 64'(resp_q.size() + iob_q.size()), 64'h0);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    iob_exp_t  ie;
    resp_exp_t re;
    if (!arst) begin
      if (bus.wb_cyc_i && bus.wb_stb_i && !bus.wb_stall_o) begin
        resp_q.push_back('{err: 1'b0,
                           data: (bus.wb_we_i ? 32'h0 : rd_model(bus.wb_addr_i))});
        iob_q.push_back('{addr: bus.wb_addr_i, wdata: bus.wb_data_i,
                          wstrb: (bus.wb_we_i ? bus.wb_select_i : 4'h0)});
      end
      if (bus.valid_o && bus.ready_i && bus.wb_cyc_i) begin
        if (iob_q.size() == 0) begin
          chk("iob_unexpected", 64'(bus.valid_o), 64'h0);
        end else begin
          ie = iob_q.pop_front();
          chk("iob_addr",  64'(bus.address_o), 64'(ie.addr));
          chk("iob_wdata", 64'(bus.wdata_o),   64'(ie.wdata));
          chk("iob_wstrb", 64'(bus.wstrb_o),   64'(ie.wstrb));
        end
      end
      if (bus.wb_ack_o || bus.wb_error_o) begin
        if (resp_q.size() == 0) begin
          chk("spurious_resp", 64'({bus.wb_ack_o, bus.wb_error_o}), 64'h0);
        end else begin
          re = resp_q.pop_front();
          n_txn++;
          $display("txn %0d: ack=%0b err=%0b data=%08h", n_txn,
                   bus.wb_ack_o, bus.wb_error_o, bus.wb_data_o);
          chk("resp_ack",  64'(bus.wb_ack_o),   64'(!re.err));
          chk("resp_err",  64'(bus.wb_error_o), 64'(re.err));
          chk("resp_data", 64'(bus.wb_data_o),  64'(re.data));
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_addr_i   = '0;
    bus.wb_select_i = '0;
    bus.wb_we_i     = 1'b0;
    bus.wb_cyc_i    = 1'b0;
    bus.wb_stb_i    = 1'b0;
    bus.wb_data_i   = '0;
    bus.ready_i     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",   64'(bus.wb_ack_o),   64'h0);
    chk("rst_err",   64'(bus.wb_error_o), 64'h0);
    chk("rst_data",  64'(bus.wb_data_o),  64'h0);
    chk("rst_valid", 64'(bus.valid_o),    64'h0);
    chk("rst_stall", 64'(bus.wb_stall_o), 64'h0);
    step();
    arst = 1'b0;

    // Single read, ready two cycles after accept
    bus.wb_cyc_i = 1'b1;
    req(1'b0, 32'h10, 4'hF, 32'h0);
    bus.wb_stb_i = 1'b0;
    @(negedge clk);
    chk("t1_valid", 64'(bus.valid_o),   64'h1);
    chk("t1_addr",  64'(bus.address_o), 64'h10);
    chk("t1_wstrb", 64'(bus.wstrb_o),   64'h0);
    step();
    bus.ready_i = 1'b1;
    step();
    bus.ready_i = 1'b0;
    @(negedge clk);
    chk("t1_ack",   64'(bus.wb_ack_o),  64'h1);
    chk("t1_rdata", 64'(bus.wb_data_o), 64'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t1_ack_once", 64'(bus.wb_ack_o), 64'h0);

    // Four back-to-back writes with ready held low fill the bridge
    step();
    for (int i = 0; i < 4; i++) req(1'b1, 32'h100 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i));
    bus.wb_stb_i = 1'b0;
    @(negedge clk);
    chk("t2_stall",   64'(bus.wb_stall_o), 64'h1);
    chk("t2_valid",   64'(bus.valid_o),    64'h1);
    chk("t2_wstrb",   64'(bus.wstrb_o),    64'hF);
    chk("t2_wdata",   64'(bus.wdata_o),    64'hA000_0000);
    step();
    step();
    @(negedge clk);
    chk("t2_stall_hold", 64'(bus.wb_stall_o), 64'h1);
    step();
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk("t2_no_ack_yet", 64'(bus.wb_ack_o), 64'h0);
    step();
    @(negedge clk);
    chk("t2_first_ack",     64'(bus.wb_ack_o),   64'h1);
    chk("t2_stall_at_ack",  64'(bus.wb_stall_o), 64'h1);
    step();
    @(negedge clk);
    chk("t2_stall_drop",    64'(bus.wb_stall_o), 64'h0);
    drain("t2_drain", 20);
    bus.ready_i = 1'b0;

    // Byte write strobes, then a read with all selects set
    req(1'b1, 32'h20, 4'b0010, 32'h11223344);
    bus.wb_stb_i = 1'b0;
    @(negedge clk);
    chk("t3_wr_wstrb", 64'(bus.wstrb_o), 64'h2);
    chk("t3_wr_wdata", 64'(bus.wdata_o), 64'h11223344);
    step();
    bus.ready_i = 1'b1;
    step();
    bus.ready_i = 1'b0;
    req(1'b0, 32'h24, 4'hF, 32'h55667788);
    bus.wb_stb_i = 1'b0;
    @(negedge clk);
    chk("t3_rd_valid", 64'(bus.valid_o), 64'h1);
    chk("t3_rd_wstrb", 64'(bus.wstrb_o), 64'h0);
    step();
    bus.ready_i = 1'b1;
    drain("t3_drain", 20);
    bus.ready_i = 1'b0;

    // Drop wb_cyc_i with three requests queued; a completion in that cycle gets no ack
    for (int i = 0; i < 3; i++) req(1'b0, 32'h200 + 32'(i * 4), 4'hF, 32'h0);
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.ready_i  = 1'b1;
    resp_q.delete();
    iob_q.delete();
    step();
    bus.ready_i = 1'b0;
    @(negedge clk);
    chk("t4_valid_flushed", 64'(bus.valid_o),    64'h0);
    chk("t4_stall_clear",   64'(bus.wb_stall_o), 64'h0);
    repeat (4) step();
    bus.wb_cyc_i = 1'b1;

    // Head waits on a stuck ready_i
    req(1'b0, 32'h300, 4'hF, 32'h0);
    bus.wb_stb_i = 1'b0;
`ifdef IOB_WB2IOB_TIMEOUT_EN
    begin : t5_timeout
      int vcnt;
      logic seen;
      vcnt = 0;
      seen = 1'b0;
      void'(resp_q.pop_front());
      resp_q.push_back('{err: 1'b1, data: 32'h0});
      iob_q.delete();
      for (int k = 0; k < 400 && !seen; k++) begin
        @(negedge clk);
        if (bus.valid_o) vcnt++;
        if (bus.wb_error_o) begin
          seen = 1'b1;
          chk("t5_ack_low", 64'(bus.wb_ack_o), 64'h0);
        end
      end
      chk("t5_err_seen",     64'(seen), 64'h1);
      chk("t5_valid_cycles", 64'(vcnt), 64'((1 << TO_W) - 1));
      step();
      drain("t5_drain", 10);
    end
`else
    repeat (40) @(negedge clk);
    chk("t5_valid_hold", 64'(bus.valid_o),    64'h1);
    chk("t5_no_err",     64'(bus.wb_error_o), 64'h0);
    step();
    bus.wb_cyc_i = 1'b0;
    resp_q.delete();
    iob_q.delete();
    step();
    bus.wb_cyc_i = 1'b1;
`endif

    // Reset in the middle of two outstanding reads
    req(1'b0, 32'h400, 4'hF, 32'h0);
    req(1'b0, 32'h404, 4'hF, 32'h0);
    bus.wb_stb_i = 1'b0;
    bus.ready_i  = 1'b1;
    step();
    bus.ready_i = 1'b0;
    arst = 1'b1;
    resp_q.delete();
    iob_q.delete();
    #1;
    chk("t6_rst_ack",   64'(bus.wb_ack_o),   64'h0);
    chk("t6_rst_err",   64'(bus.wb_error_o), 64'h0);
    chk("t6_rst_data",  64'(bus.wb_data_o),  64'h0);
    chk("t6_rst_valid", 64'(bus.valid_o),    64'h0);
    chk("t6_rst_stall", 64'(bus.wb_stall_o), 64'h0);
    step();
    step();
    arst = 1'b0;
    repeat (5) step();
    req(1'b0, 32'h10, 4'hF, 32'h0);
    bus.wb_stb_i = 1'b0;
    bus.ready_i  = 1'b1;
    drain("t6_after_reset", 20);
    bus.ready_i = 1'b0;

    // Random traffic: exercises pointer wrap and push/pop at the full boundary
    for (int c = 0; c < 200; c++) begin
      bus.wb_stb_i    = ($urandom_range(0, 3) != 0);
      bus.wb_we_i     = ($urandom_range(0, 1) != 0);
      bus.wb_addr_i   = 32'($urandom_range(0, 1023)) << 2;
      bus.wb_select_i = 4'($urandom);
      bus.wb_data_i   = $urandom;
      bus.ready_i     = ($urandom_range(0, 2) != 0);
      step();
    end
    bus.wb_stb_i = 1'b0;
    bus.ready_i  = 1'b1;
    drain("t7_drain", 50);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/iob_wishbone2iob_pipe.md
IOB_WISHBONE2IOB_PIPE -- requirements
Module: iob_wishbone2iob_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width, multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 4, max outstanding requests, power of 2, >=2.
REQ-004 SHALL have parameter TIMEOUT_W, default 8, width of the timeout counter.
REQ-005 SHALL have port clk_i, input, 1, single clock, all logic on rising edge.
REQ-006 SHALL have port arst_i, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have Wishbone inputs: wb_addr_i ADDR_W, wb_select_i DATA_W/8, wb_we_i 1, wb_cyc_i 1, wb_stb_i 1, wb_data_i DATA_W.
REQ-008 SHALL have Wishbone outputs: wb_stall_o 1, wb_ack_o 1, wb_error_o 1, wb_data_o DATA_W.
REQ-009 SHALL have IOb outputs: valid_o 1, address_o ADDR_W, wdata_o DATA_W, wstrb_o DATA_W/8.
REQ-010 SHALL have IOb inputs: rdata_i DATA_W, ready_i 1.

Function
REQ-011 SHALL accept a Wishbone request in any cycle with wb_cyc_i & wb_stb_i & ~wb_stall_o; pipelined mode, one request per cycle max.
REQ-012 SHALL push each accepted request {addr, data, select, we} into a DEPTH-entry request FIFO.
REQ-013 SHALL keep an outstanding counter (0..DEPTH): +1 on accept, -1 on ack/error issue, net 0 when both occur in the same cycle.
REQ-014 SHALL drive wb_stall_o = 1 when outstanding == DEPTH, else 0 (combinational from the counter).
REQ-015 SHALL drive valid_o from the FIFO head whenever the FIFO is non-empty, with address_o = head addr, wdata_o = head data, wstrb_o = head we ? head select : 0.
REQ-016 SHALL complete an IOb transaction in the cycle valid_o & ready_i; rdata_i is valid in that cycle for reads; head pops on that edge.
REQ-017 SHALL hold valid_o and head fields stable until completion; new head presented the following cycle (no bubble when more entries are queued).
REQ-018 SHALL register completion: wb_ack_o = 1 for exactly one cycle, one clock after IOb completion; wb_data_o = captured rdata_i for reads, 0 for writes.
REQ-019 SHALL return acks in request order; ack count equals accept count per cycle of wb_cyc_i.
REQ-020 SHALL ignore ready_i when valid_o is 0.
REQ-021 SHALL, on wb_cyc_i falling to 0, flush all FIFO entries and clear the outstanding counter next edge; a completion in that same cycle produces no ack.
REQ-022 SHALL accept a push into a full FIFO slot freed by a pop in the same cycle (simultaneous push/pop at DEPTH-1 outstanding).
REQ-023 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-024 SHALL, while arst_i = 1, force wb_ack_o, wb_error_o, wb_data_o, valid_o, wb_stall_o to 0, empty the FIFO, and zero the outstanding and timeout counters.
REQ-025 SHALL discard any in-flight request on reset mid-operation; no ack or error after reset release.

Configuration
REQ-026 SHALL compile the timeout feature only when macro IOB_WB2IOB_TIMEOUT_EN is defined.
REQ-027 With IOB_WB2IOB_TIMEOUT_EN: a TIMEOUT_W counter SHALL count cycles of valid_o & ~ready_i, clear on completion/pop; on reaching 2^TIMEOUT_W-1 the head SHALL pop, valid_o drop one cycle, and wb_error_o (not wb_ack_o) pulse one cycle next edge with wb_data_o = 0.
REQ-028 Without IOB_WB2IOB_TIMEOUT_EN: wb_error_o SHALL be constant 0 and the bridge SHALL wait indefinitely for ready_i.

Verification
REQ-029 Single read: accept addr 0x10, ready_i=1 with rdata_i=0xDEADBEEF two cycles later -> wb_ack_o=1 one cycle after, wb_data_o=0xDEADBEEF.
REQ-030 Back-to-back 4 writes (DEPTH=4), ready_i held 0 -> wb_stall_o=1 after 4th accept; wstrb_o=0xF on first valid_o; release ready_i -> 4 acks in order, stall drops the cycle after first ack.
REQ-031 Byte write sel=4'b0010, we=1 -> wstrb_o=4'b0010, wdata_o=wb_data_i; read sel=4'b1111, we=0 -> wstrb_o=0.
REQ-032 Drop wb_cyc_i with 3 requests queued -> next cycle valid_o=0, outstanding=0, no ack ever for those requests.
REQ-033 TIMEOUT_EN, TIMEOUT_W=4, ready_i stuck 0 -> valid_o high 15 cycles, then wb_error_o=1 one cycle, wb_ack_o=0; without macro -> valid_o stays high, wb_error_o=0.
REQ-034 arst_i pulsed with 2 outstanding reads -> all outputs 0 during reset, no ack/error after release, next request served normally.
